// File: rtl/bram_pkg.sv
// Shared definitions for the BRAM arbiter: requester IDs, width defaults,
// the return-pipeline entry, and the round-robin successor helpers.
package bram_pkg;

  localparam int ADDR_W_DFLT = 13;
  localparam int DATA_W_DFLT = 32;

  localparam logic [1:0] REQ_DMA = 2'b00;
  localparam logic [1:0] REQ_CPU = 2'b01;
  localparam logic [1:0] REQ_PF  = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] sel;
  } ret_entry_t;

  function automatic logic [1:0] next_req(input logic [1:0] id);
    case (id)
      REQ_DMA: next_req = REQ_CPU;
      REQ_CPU: next_req = REQ_PF;
      default: next_req = REQ_DMA;
    endcase
  endfunction

  function automatic logic [2:0] req_onehot(input logic [1:0] id);
    req_onehot = 3'b001 << id;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_arb3.sv
// 3-way round-robin arbiter. Search starts at the requester after the one
// granted most recently; the pointer only moves when a grant is given.
module rr_arb3
  import bram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  logic [1:0] last_q;
  logic [1:0] last_d;
  logic [1:0] cand;

  // NOTE: every signal written here gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ_DMA;
    cand      = next_req(last_q);
    for (int i = 0; i < 3; i++) begin
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
      cand = next_req(cand);
    end
    gnt    = gnt_valid ? req_onehot(gnt_id) : 3'b000;
    last_d = gnt_valid ? gnt_id : last_q;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_PF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one fixed-latency BRAM controller between DMA, CPU cache and prefetch:
// round-robin issue, per-requester read-valid via a return pipeline, prefetch cancel.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int RD_LAT = 11
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,

  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              pf_cancel,
  output logic              pf_gnt,
  output logic              pf_rvalid,
  output logic [DATA_W-1:0] pf_rdata,

  output logic              bram_valid,
  output logic              bram_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic [1:0]        bram_sel,
  input  logic [DATA_W-1:0] bram_rdata,

  output logic              busy
);

  logic [2:0] req_vec;
  logic [2:0] gnt_vec;
  logic [2:0] rd_gnt_vec;
  logic [2:0] rvalid_vec;
  logic [1:0] gnt_id;
  logic       gnt_any;

  // Cancel blocks new prefetch grants; reset hides every grant while held.
  assign req_vec = {pf_req & ~pf_cancel, cpu_req, dma_req} & {3{rst_n}};

  rr_arb3 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_vec),
    .gnt       (gnt_vec),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_any)
  );

  assign dma_gnt    = gnt_vec[REQ_DMA];
  assign cpu_gnt    = gnt_vec[REQ_CPU];
  assign pf_gnt     = gnt_vec[REQ_PF];
  assign rd_gnt_vec = gnt_vec & {1'b1, ~cpu_wr, ~dma_wr};

  logic              bram_valid_q, bram_valid_d;
  logic              bram_wr_q,    bram_wr_d;
  logic [ADDR_W-1:0] bram_addr_q,  bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic [1:0]        bram_sel_q,   bram_sel_d;

  always_comb begin
    bram_valid_d = gnt_any;
    bram_wr_d    = bram_wr_q;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    bram_sel_d   = bram_sel_q;
    if (gnt_any) begin
      bram_sel_d = gnt_id;
      case (gnt_id)
        REQ_DMA: begin
          bram_wr_d    = dma_wr;
          bram_addr_d  = dma_addr;
          bram_wdata_d = dma_wdata;
        end
        REQ_CPU: begin
          bram_wr_d    = cpu_wr;
          bram_addr_d  = cpu_addr;
          bram_wdata_d = cpu_wdata;
        end
        default: begin
          bram_wr_d   = 1'b0;
          bram_addr_d = pf_addr;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_valid_q <= 1'b0;
      bram_wr_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      bram_sel_q   <= REQ_DMA;
    end else begin
      bram_valid_q <= bram_valid_d;
      bram_wr_q    <= bram_wr_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      bram_sel_q   <= bram_sel_d;
    end
  end

  assign bram_valid = bram_valid_q;
  assign bram_wr    = bram_wr_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;
  assign bram_sel   = bram_sel_q;

  ret_entry_t [RD_LAT-1:0] pipe_q;
  ret_entry_t [RD_LAT-1:0] pipe_d;
  ret_entry_t              tail;

  always_comb begin
    pipe_d[0] = ret_entry_t'{valid: bram_valid_q & ~bram_wr_q, sel: bram_sel_q};
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (pf_cancel) begin
      for (int i = 0; i < RD_LAT; i++) begin
        if (pipe_d[i].sel == REQ_PF) pipe_d[i].valid = 1'b0;
      end
    end
  end

  // NOTE: the return pipeline is reset (unlike a data RAM) because stale valid bits would fire rvalid for reads lost in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail = pipe_q[RD_LAT-1];

  // A prefetch entry reaching the tail in a cancel cycle is dropped too.
  always_comb begin
    rvalid_vec = 3'b000;
    if (tail.valid) rvalid_vec = req_onehot(tail.sel);
    if (pf_cancel) rvalid_vec[REQ_PF] = 1'b0;
  end

  assign dma_rvalid = rvalid_vec[REQ_DMA];
  assign cpu_rvalid = rvalid_vec[REQ_CPU];
  assign pf_rvalid  = rvalid_vec[REQ_PF];
  assign dma_rdata  = bram_rdata;
  assign cpu_rdata  = bram_rdata;
  assign pf_rdata   = bram_rdata;

  logic [2:0][3:0] cnt_q;
  logic [2:0][3:0] cnt_d;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i] + {3'b000, rd_gnt_vec[i]} - {3'b000, rvalid_vec[i]};
    end
    if (pf_cancel) cnt_d[REQ_PF] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = |cnt_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a fixed-latency BRAM controller model;
// expected values are hand-derived from the grant-to-rvalid latency of RD_LAT+1.
module tb_bram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 11;

  logic              clk;
  logic              rst_n;
  logic              dma_req, dma_wr, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              pf_req, pf_cancel, pf_gnt, pf_rvalid;
  logic [ADDR_W-1:0] pf_addr;
  logic [DATA_W-1:0] pf_rdata;
  logic              bram_valid, bram_wr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;
  logic [1:0]        bram_sel;
  logic              busy;

  int checks;
  int errors;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dma_req    (dma_req),
    .dma_wr     (dma_wr),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .pf_req     (pf_req),
    .pf_addr    (pf_addr),
    .pf_cancel  (pf_cancel),
    .pf_gnt     (pf_gnt),
    .pf_rvalid  (pf_rvalid),
    .pf_rdata   (pf_rdata),
    .bram_valid (bram_valid),
    .bram_wr    (bram_wr),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_sel   (bram_sel),
    .bram_rdata (bram_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: writes land at the edge after bram_valid, read data
  // appears RD_LAT cycles after the bram_valid cycle.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  bit                mem_init_done;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 32'h5A00_0000 | i;
      mem_init_done <= 1'b1;
    end else if (bram_valid && bram_wr) begin
      mem[bram_addr] <= bram_wdata;
    end
    rd_pipe[0] <= (bram_valid && !bram_wr) ? mem[bram_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bram_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    pf_req = 0; pf_addr = '0; pf_cancel = 0;

    // Reset state
    #3;
    check("rst_gnt", {pf_gnt, cpu_gnt, dma_gnt}, 0);
    check("rst_bram_valid", bram_valid, 0);
    check("rst_bram_wr", bram_wr, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_wdata", bram_wdata, 0);
    check("rst_bram_sel", bram_sel, 0);
    check("rst_rvalid", {pf_rvalid, cpu_rvalid, dma_rvalid}, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All three read continuously for 12 cycles from reset
    dma_addr = 13'h100; cpu_addr = 13'h101; pf_addr = 13'h102;
    for (int c = 0; c <= 24; c++) begin
      cycle();
      dma_req = (c < 12); cpu_req = (c < 12); pf_req = (c < 12);
      #1;
      check("rr_gnt", {pf_gnt, cpu_gnt, dma_gnt}, (c < 12) ? (32'd1 << (c % 3)) : 32'd0);
      check("rr_rvalid", {pf_rvalid, cpu_rvalid, dma_rvalid},
            (c >= 12 && c < 24) ? (32'd1 << ((c - 12) % 3)) : 32'd0);
      check("rr_busy", busy, (c >= 1 && c <= 23));
      if (c >= 12 && c < 24) begin
        case ((c - 12) % 3)
          0:       check("rr_rdata_dma", dma_rdata, 32'h5A00_0100);
          1:       check("rr_rdata_cpu", cpu_rdata, 32'h5A00_0101);
          default: check("rr_rdata_pf", pf_rdata, 32'h5A00_0102);
        endcase
      end
    end

    // DMA write 0xDEADBEEF to 0x010, then single CPU read of it
    cycle();
    dma_req = 1; dma_wr = 1; dma_addr = 13'h010; dma_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_dma_gnt", {pf_gnt, cpu_gnt, dma_gnt}, 3'b001);
    cycle();
    dma_req = 0; dma_wr = 0;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 13'h010;
    #1;
    check("wr_bram_valid", bram_valid, 1);
    check("wr_bram_wr", bram_wr, 1);
    check("wr_bram_addr", bram_addr, 32'h010);
    check("wr_bram_wdata", bram_wdata, 32'hDEAD_BEEF);
    check("wr_bram_sel", bram_sel, 2'b00);
    check("rd_cpu_gnt", {pf_gnt, cpu_gnt, dma_gnt}, 3'b010);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      cycle();
      cpu_req = 0;
      #1;
      if (k == 1) begin
        check("rd_bram_sel", bram_sel, 2'b01);
        check("rd_bram_wr", bram_wr, 0);
      end
      check("rd_cpu_rvalid", cpu_rvalid, (k == RD_LAT + 1));
      check("rd_other_rvalid", {pf_rvalid, dma_rvalid}, 0);
      check("rd_busy", busy, 1);
      if (k == RD_LAT + 1) check("rd_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    end
    cycle();
    #1;
    check("rd_busy_fall", busy, 0);

    // DMA writes 1..8 to 0..7 back-to-back, CPU reads them back
    for (int c = 0; c <= 28; c++) begin
      cycle();
      dma_req = (c < 8); dma_wr = 1; dma_addr = ADDR_W'(c); dma_wdata = DATA_W'(c + 1);
      cpu_req = (c >= 8 && c < 16); cpu_wr = 0; cpu_addr = ADDR_W'(c - 8);
      #1;
      check("b2b_dma_gnt", dma_gnt, (c < 8));
      check("b2b_cpu_gnt", cpu_gnt, (c >= 8 && c < 16));
      check("b2b_bram_valid", bram_valid, (c >= 1 && c <= 16));
      check("b2b_bram_wr", bram_wr, (c >= 1 && c <= 8));
      check("b2b_cpu_rvalid", cpu_rvalid, (c >= 20 && c <= 27));
      check("b2b_dma_rvalid", dma_rvalid, 0);
      check("b2b_busy", busy, (c >= 9 && c <= 27));
      if (c >= 20 && c <= 27) check("b2b_rdata", cpu_rdata, 32'(c - 19));
    end
    dma_req = 0; dma_wr = 0; cpu_req = 0;

    // Four PF reads plus one CPU read; cancel three cycles after the last PF issue
    for (int c = 0; c <= 17; c++) begin
      cycle();
      pf_req = (c < 4); pf_addr = ADDR_W'(13'h300 + c);
      cpu_req = (c == 4); cpu_wr = 0; cpu_addr = 13'h010;
      pf_cancel = (c == 6);
      #1;
      check("cxl_pf_gnt", pf_gnt, (c < 4));
      check("cxl_cpu_gnt", cpu_gnt, (c == 4));
      check("cxl_pf_rvalid", pf_rvalid, 0);
      check("cxl_cpu_rvalid", cpu_rvalid, (c == 16));
      check("cxl_busy", busy, (c >= 1 && c <= 16));
      if (c == 16) check("cxl_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    end
    pf_cancel = 0;

    // Reset for one cycle with five reads in flight
    dma_addr = 13'h200; cpu_addr = 13'h201; dma_wr = 0; cpu_wr = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      dma_req = 1; cpu_req = 1;
      #1;
      check("mid_pre_gnt", 32'(dma_gnt) + 32'(cpu_gnt) + 32'(pf_gnt), 1);
    end
    cycle();
    rst_n = 1'b0; cpu_req = 0;
    #1;
    check("mid_rst_gnt", {pf_gnt, cpu_gnt, dma_gnt}, 0);
    check("mid_rst_bram_valid", bram_valid, 0);
    check("mid_rst_bram_addr", bram_addr, 0);
    check("mid_rst_bram_sel", bram_sel, 0);
    check("mid_rst_rvalid", {pf_rvalid, cpu_rvalid, dma_rvalid}, 0);
    check("mid_rst_busy", busy, 0);
    cycle();
    rst_n = 1'b1;
    pf_addr = 13'h202;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) cycle();
      dma_req = (c < 1); cpu_req = (c < 2); pf_req = (c < 3);
      #1;
      check("post_rst_gnt", {pf_gnt, cpu_gnt, dma_gnt}, (c < 3) ? (32'd1 << c) : 32'd0);
      check("post_rst_rvalid", {pf_rvalid, cpu_rvalid, dma_rvalid},
            (c >= 12 && c < 15) ? (32'd1 << (c - 12)) : 32'd0);
      check("post_rst_busy", busy, (c >= 1 && c <= 14));
    end

    // PF request during cancel with no other requester: nothing issues
    cycle();
    pf_req = 1; pf_addr = 13'h3FF; pf_cancel = 1; dma_req = 0; cpu_req = 0;
    #1;
    check("cxl_only_gnt", {pf_gnt, cpu_gnt, dma_gnt}, 0);
    cycle();
    #1;
    check("cxl_only_bram_valid", bram_valid, 0);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 13'h020;
    #1;
    check("cxl_cpu_wins", {pf_gnt, cpu_gnt, dma_gnt}, 3'b010);
    cycle();
    cpu_req = 0; pf_cancel = 0;
    #1;
    check("cxl_pf_after", {pf_gnt, cpu_gnt, dma_gnt}, 3'b100);
    check("cxl_pf_after_sel", bram_sel, 2'b01);

    // Cancel in the very cycle the PF entry reaches the tail
    for (int k = 1; k <= 13; k++) begin
      cycle();
      pf_req = 0;
      pf_cancel = (k == 12);
      #1;
      check("tail_cpu_rvalid", cpu_rvalid, (k == 11));
      check("tail_pf_rvalid", pf_rvalid, 0);
      check("tail_busy", busy, (k <= 12));
      if (k == 11) check("tail_cpu_rdata", cpu_rdata, 32'h5A00_0020);
    end
    pf_cancel = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
